// File: rtl/gpr_mt.sv
// Multi-threaded general-purpose register file: THREADS banks of DEPTH registers, each with a
// pending-write busy bit, two combinational read ports with write bypass, and a post-reset clear sweep.
module gpr_mt #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int TID_W  = 2
) (
    input  logic              clk,
    input  logic              reset_,
    output logic              ready,
    input  logic [TID_W-1:0]  rd_tid_0,
    input  logic [TID_W-1:0]  rd_tid_1,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1,
    output logic              rd_busy_0,
    output logic              rd_busy_1,
    input  logic              we_,
    input  logic [TID_W-1:0]  wr_tid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sb_set_,
    input  logic [TID_W-1:0]  sb_tid,
    input  logic [ADDR_W-1:0] sb_addr
);

    localparam int IDX_W   = TID_W + ADDR_W;
    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_nxt;

    logic [DATA_W-1:0] r_mem [ENTRIES];
    logic [ENTRIES-1:0] r_busy;

    logic              w_run;
    logic              w_wr_act;
    logic              w_sb_act;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_sb_idx;

    assign w_run    = (r_state == RUN);
    assign ready    = w_run;
    assign w_wr_idx = {wr_tid, wr_addr};
    assign w_sb_idx = {sb_tid, sb_addr};
    // Address 0 is hardwired zero, so accesses to it are dropped before they reach the array.
    assign w_wr_act = w_run && !we_     && (wr_addr != '0);
    assign w_sb_act = w_run && !sb_set_ && (sb_addr != '0);

    // Control state: sweep counter stops at the last entry and RUN holds until reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == CLEAR) begin
            if (r_cnt == LAST_IDX) begin
                w_state_nxt = RUN;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Storage: the sweep zeroes one entry per cycle; in RUN a mark after the write-clear lets a new producer win.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt]  <= '0;
            r_busy[r_cnt] <= 1'b0;
        end else begin
            if (w_wr_act) begin
                r_mem[w_wr_idx]  <= wr_data;
                r_busy[w_wr_idx] <= 1'b0;
            end
            if (w_sb_act) begin
                r_busy[w_sb_idx] <= 1'b1;
            end
        end
    end

    logic [TID_W-1:0]  w_rtid  [2];
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rbusy [2];

    assign w_rtid[0]  = rd_tid_0;
    assign w_rtid[1]  = rd_tid_1;
    assign w_raddr[0] = rd_addr_0;
    assign w_raddr[1] = rd_addr_1;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic [IDX_W-1:0] w_idx;
        logic             w_zero;
        logic             w_hit;

        assign w_idx  = {w_rtid[p], w_raddr[p]};
        // Contents are undefined until the sweep finishes, so reads are forced to zero outside RUN.
        assign w_zero = !w_run || (w_raddr[p] == '0);
        assign w_hit  = w_wr_act && (w_idx == w_wr_idx);

        assign w_rdata[p] = w_zero ? '0 : (w_hit ? wr_data : r_mem[w_idx]);
        assign w_rbusy[p] = w_zero ? 1'b0 : (w_hit ? 1'b0 : r_busy[w_idx]);
    end

    assign rd_data_0 = w_rdata[0];
    assign rd_data_1 = w_rdata[1];
    assign rd_busy_0 = w_rbusy[0];
    assign rd_busy_1 = w_rbusy[1];

endmodule

// File: tb/tb_gpr_mt.sv
// Directed bench for gpr_mt: the driver queues expected read/ready values stamped with a cycle,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_gpr_mt;

    logic        clk = 1'b0;
    logic        reset_;
    logic        ready;
    logic [1:0]  rd_tid_0, rd_tid_1;
    logic [4:0]  rd_addr_0, rd_addr_1;
    logic [31:0] rd_data_0, rd_data_1;
    logic        rd_busy_0, rd_busy_1;
    logic        we_;
    logic [1:0]  wr_tid;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sb_set_;
    logic [1:0]  sb_tid;
    logic [4:0]  sb_addr;

    gpr_mt #(.DATA_W(32), .ADDR_W(5), .TID_W(2)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .ready     (ready),
        .rd_tid_0  (rd_tid_0),
        .rd_tid_1  (rd_tid_1),
        .rd_addr_0 (rd_addr_0),
        .rd_addr_1 (rd_addr_1),
        .rd_data_0 (rd_data_0),
        .rd_data_1 (rd_data_1),
        .rd_busy_0 (rd_busy_0),
        .rd_busy_1 (rd_busy_1),
        .we_       (we_),
        .wr_tid    (wr_tid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sb_set_   (sb_set_),
        .sb_tid    (sb_tid),
        .sb_addr   (sb_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;   // 0: port 0, 1: port 1, 2: ready
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   k;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: check for cycle %0d reached at cycle %0d", e.name, e.cyc, cyc);
            end else if (e.kind == 0) begin
                if (rd_data_0 !== e.data || rd_busy_0 !== e.busy) begin
                    n_err++;
                    $display("FAIL %s: port0 got data=%h busy=%b, need data=%h busy=%b",
                             e.name, rd_data_0, rd_busy_0, e.data, e.busy);
                end
            end else if (e.kind == 1) begin
                if (rd_data_1 !== e.data || rd_busy_1 !== e.busy) begin
                    n_err++;
                    $display("FAIL %s: port1 got data=%h busy=%b, need data=%h busy=%b",
                             e.name, rd_data_1, rd_busy_1, e.data, e.busy);
                end
            end else begin
                if (ready !== e.busy) begin
                    n_err++;
                    $display("FAIL %s: ready got %b, need %b", e.name, ready, e.busy);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [31:0] d, input logic b, input string nm);
        exp_t x;
        x.cyc  = cyc;
        x.kind = kind;
        x.data = d;
        x.busy = b;
        x.name = nm;
        sbq.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic idle();
        we_     = 1'b1;
        sb_set_ = 1'b1;
    endtask

    task automatic rd(input logic [1:0] t0, input logic [4:0] a0, input logic [1:0] t1, input logic [4:0] a1);
        rd_tid_0  = t0;
        rd_addr_0 = a0;
        rd_tid_1  = t1;
        rd_addr_1 = a1;
    endtask

    task automatic wr(input logic [1:0] t, input logic [4:0] a, input logic [31:0] d);
        we_     = 1'b0;
        wr_tid  = t;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic mark(input logic [1:0] t, input logic [4:0] a);
        sb_set_ = 1'b0;
        sb_tid  = t;
        sb_addr = a;
    endtask

    initial begin
        reset_ = 1'b0;
        idle();
        wr(2'd0, 5'd0, 32'h0);
        we_ = 1'b1;
        mark(2'd0, 5'd0);
        sb_set_ = 1'b1;
        rd(2'd2, 5'd7, 2'd3, 5'd31);
        step();
        step();
        push(2, 32'h0, 1'b0, "reset_ready");
        push(0, 32'h0, 1'b0, "reset_rd0");
        push(1, 32'h0, 1'b0, "reset_rd1");

        // Full sweep from reset release.
        reset_ = 1'b1;
        k = cyc;
        step_to(k + 127);
        push(2, 32'h0, 1'b0, "sweep_ready_127");
        step();
        push(2, 32'h0, 1'b1, "sweep_ready_128");
        for (int i = 0; i < 64; i++) begin
            rd(i[6:5], i[4:0], 2'(i / 32 + 2), i[4:0]);
            push(0, 32'h0, 1'b0, "cleared_lo");
            push(1, 32'h0, 1'b0, "cleared_hi");
            step();
        end

        // Write with same-cycle bypass, then bank isolation.
        wr(2'd2, 5'd7, 32'hDEADBEEF);
        rd(2'd2, 5'd7, 2'd1, 5'd7);
        push(0, 32'hDEADBEEF, 1'b0, "bypass_t2a7");
        push(1, 32'h0, 1'b0, "iso_t1a7_same");
        step();
        idle();
        push(0, 32'hDEADBEEF, 1'b0, "stored_t2a7");
        push(1, 32'h0, 1'b0, "iso_t1a7_next");
        step();

        // Scoreboard mark, then write clearing busy.
        mark(2'd3, 5'd9);
        rd(2'd3, 5'd9, 2'd2, 5'd9);
        push(0, 32'h0, 1'b0, "mark_same_cycle");
        step();
        idle();
        push(0, 32'h0, 1'b1, "mark_next_cycle");
        push(1, 32'h0, 1'b0, "mark_iso_t2a9");
        step();
        wr(2'd3, 5'd9, 32'd5);
        push(0, 32'd5, 1'b0, "wr_bypass_busy");
        step();
        idle();
        push(0, 32'd5, 1'b0, "wr_stored_busy");
        step();

        // Same-entry write-clear and mark: mark wins.
        wr(2'd0, 5'd4, 32'hA5A5_5A5A);
        mark(2'd0, 5'd4);
        rd(2'd0, 5'd4, 2'd1, 5'd4);
        push(0, 32'hA5A5_5A5A, 1'b0, "wr_mark_same");
        push(1, 32'h0, 1'b0, "wr_mark_iso");
        step();
        idle();
        push(0, 32'hA5A5_5A5A, 1'b1, "wr_mark_next");
        step();

        // Address 0 is hardwired.
        wr(2'd1, 5'd0, 32'h1234);
        mark(2'd1, 5'd0);
        rd(2'd1, 5'd0, 2'd1, 5'd0);
        push(0, 32'h0, 1'b0, "addr0_p0_same");
        push(1, 32'h0, 1'b0, "addr0_p1_same");
        step();
        idle();
        push(0, 32'h0, 1'b0, "addr0_p0_next");
        push(1, 32'h0, 1'b0, "addr0_p1_next");
        step();

        // Port 1 bypass at the top entry, port 0 on the neighbouring bank.
        wr(2'd2, 5'd31, 32'hFFFF_FFFF);
        rd(2'd3, 5'd31, 2'd2, 5'd31);
        push(0, 32'h0, 1'b0, "top_iso_t3a31");
        push(1, 32'hFFFF_FFFF, 1'b0, "top_bypass_p1");
        step();
        idle();
        rd(2'd2, 5'd31, 2'd2, 5'd31);
        push(0, 32'hFFFF_FFFF, 1'b0, "top_stored_p0");
        push(1, 32'hFFFF_FFFF, 1'b0, "top_stored_p1");
        step();

        // Reset mid-RUN, then again mid-sweep at count 40.
        rd(2'd2, 5'd7, 2'd3, 5'd9);
        reset_ = 1'b0;
        push(2, 32'h0, 1'b0, "runrst_ready");
        push(0, 32'h0, 1'b0, "runrst_rd0");
        push(1, 32'h0, 1'b0, "runrst_rd1");
        step();
        reset_ = 1'b1;
        k = cyc;
        step_to(k + 40);
        reset_ = 1'b0;
        push(2, 32'h0, 1'b0, "midsweep_rst_ready");
        step();
        step();
        reset_ = 1'b1;
        k = cyc;
        step_to(k + 10);
        push(0, 32'h0, 1'b0, "clear_gated_rd0");
        push(1, 32'h0, 1'b0, "clear_gated_rd1");
        push(2, 32'h0, 1'b0, "resweep_ready_10");
        step_to(k + 100);
        wr(2'd0, 5'd5, 32'h55);
        mark(2'd0, 5'd6);
        rd(2'd0, 5'd5, 2'd0, 5'd6);
        push(0, 32'h0, 1'b0, "clear_wr_nobypass");
        step_to(k + 127);
        push(2, 32'h0, 1'b0, "resweep_ready_127");
        step();
        idle();
        push(2, 32'h0, 1'b1, "resweep_ready_128");
        push(0, 32'h0, 1'b0, "clear_wr_dropped");
        push(1, 32'h0, 1'b0, "clear_mark_dropped");
        step();
        rd(2'd2, 5'd7, 2'd3, 5'd9);
        push(0, 32'h0, 1'b0, "resweep_t2a7");
        push(1, 32'h0, 1'b0, "resweep_t3a9");
        step();
        step();
        step();

        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d checks left unmonitored, need 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
